// File: rtl/lsu_mem_if.sv
// lsu_mem_if: data-memory req/ack bus between the LSU (master) and memory (slave).
interface lsu_mem_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  bmask;
  logic        ack;
  logic [31:0] rdata;
  modport master (output req, we, addr, wdata, bmask, input ack, rdata);
  modport slave  (input req, we, addr, wdata, bmask, output ack, rdata);
endinterface

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: MEM-stage load/store unit; one bus transaction per access, stalls until done.
module lsu_mem_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic        i_is_load,
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  lsu_mem_if.master   mem,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_ld_data,
  output logic        o_misaligned,
  output logic        o_bus_err
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, ld_data_q, ld_data_d;
  logic [2:0]    f3_q, f3_d;
  logic          we_q, we_d, mis_q, mis_d, berr_q, berr_d;
  logic          accept, bad, timeout, in_req;
  logic [1:0]    b;
  logic [31:0]   sh, ext, lanes;
  logic [3:0]    bmask;
  always_comb begin
    accept  = i_valid & (i_is_load | i_is_store);
    bad     = (i_funct3[1:0] == 2'b11) | (i_funct3 == 3'b110) | (i_is_store & i_funct3[2]) |
              ((i_funct3[1:0] == 2'b01) & i_addr[0]) | ((i_funct3[1:0] == 2'b10) & (i_addr[1:0] != 2'b00));
    timeout = cnt_q == CW'(TIMEOUT_CYCLES - 1);
    b       = addr_q[1:0];
    sh      = mem.rdata >> {b, 3'b000};
    ext     = f3_q == 3'b000 ? {{24{sh[7]}}, sh[7:0]} :
              f3_q == 3'b001 ? {{16{sh[15]}}, sh[15:0]} :
              f3_q == 3'b100 ? {24'b0, sh[7:0]} :
              f3_q == 3'b101 ? {16'b0, sh[15:0]} : sh;
    bmask   = (!we_q || f3_q[1]) ? 4'b1111 : f3_q[0] ? 4'b0011 << b : 4'b0001 << b;
    lanes   = f3_q[1] ? wdata_q : f3_q[0] ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
  end
  // Flags and load data are only set on the transition into DONE, so they self-clear after it.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    f3_d      = f3_q;
    we_d      = we_q;
    cnt_d     = '0;
    mis_d     = 1'b0;
    berr_d    = 1'b0;
    ld_data_d = '0;
    unique case (state_q)
      IDLE: if (accept) begin
        addr_d  = i_addr;
        wdata_d = i_wdata;
        f3_d    = i_funct3;
        we_d    = i_is_store;
        mis_d   = bad;
        state_d = bad ? DONE : REQ;
      end
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (mem.ack) begin
          ld_data_d = ext;
          state_d   = DONE;
        end else if (timeout) begin
          berr_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      f3_q      <= '0;
      we_q      <= 1'b0;
      mis_q     <= 1'b0;
      berr_q    <= 1'b0;
      ld_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      f3_q      <= f3_d;
      we_q      <= we_d;
      mis_q     <= mis_d;
      berr_q    <= berr_d;
      ld_data_q <= ld_data_d;
    end
  end
  assign in_req       = state_q == REQ;
  assign mem.req      = in_req;
  assign mem.we       = in_req & we_q;
  assign mem.addr     = in_req ? {addr_q[31:2], 2'b00} : '0;
  assign mem.bmask    = in_req ? bmask : '0;
  assign mem.wdata    = (in_req & we_q) ? lanes : '0;
  // Gated by reset so an instruction still held at i_valid cannot stall during reset.
  assign o_stall      = i_rst_n & (in_req | ((state_q == IDLE) & accept));
  assign o_done       = state_q == DONE;
  assign o_ld_data    = o_done ? ld_data_q : '0;
  assign o_misaligned = o_done & mis_q;
  assign o_bus_err    = o_done & berr_q;
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: directed scenario tests for lsu_mem_stage with hand-computed expectations.
module tb_lsu_mem_stage;
  logic        i_clk, i_rst_n, i_valid, i_is_load, i_is_store;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr, i_wdata, o_ld_data;
  logic        o_stall, o_done, o_misaligned, o_bus_err;
  int          pass, total;
  lsu_mem_if mem_if ();
  lsu_mem_stage #(.TIMEOUT_CYCLES(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_is_load(i_is_load),
    .i_is_store(i_is_store), .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
    .mem(mem_if.master), .o_stall(o_stall), .o_done(o_done), .o_ld_data(o_ld_data),
    .o_misaligned(o_misaligned), .o_bus_err(o_bus_err)
  );
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    i_valid = 1'b1; i_is_load = ld; i_is_store = st; i_funct3 = f3; i_addr = a; i_wdata = wd;
  endtask

  task automatic test_reset;
    #3;
    total++; if ({mem_if.req, o_stall, o_done, o_misaligned, o_bus_err} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000", {mem_if.req, o_stall, o_done, o_misaligned, o_bus_err}); else pass++;
    total++; if (o_ld_data !== 32'h0) $display("FAIL reset_ld_data: got %h want 0", o_ld_data); else pass++;
    tick;
    i_rst_n = 1'b1;
  endtask

  task automatic test_sw;
    issue(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF); #1;
    total++; if ({o_stall, mem_if.req} !== 2'b10) $display("FAIL sw_accept_stall_req: got %b want 10", {o_stall, mem_if.req}); else pass++;
    tick; i_valid = 1'b0; mem_if.ack = 1'b1; #1;
    total++; if ({mem_if.req, mem_if.we, o_stall, o_done} !== 4'b1110) $display("FAIL sw_req_we_stall_done: got %b want 1110", {mem_if.req, mem_if.we, o_stall, o_done}); else pass++;
    total++; if (mem_if.addr !== 32'h100) $display("FAIL sw_addr: got %h want 00000100", mem_if.addr); else pass++;
    total++; if (mem_if.bmask !== 4'b1111) $display("FAIL sw_bmask: got %b want 1111", mem_if.bmask); else pass++;
    total++; if (mem_if.wdata !== 32'hDEADBEEF) $display("FAIL sw_wdata: got %h want deadbeef", mem_if.wdata); else pass++;
    tick; mem_if.ack = 1'b0; #1;
    total++; if ({o_done, o_stall, o_misaligned, o_bus_err, mem_if.req} !== 5'b10000) $display("FAIL sw_done: got %b want 10000", {o_done, o_stall, o_misaligned, o_bus_err, mem_if.req}); else pass++;
    tick;
    total++; if (o_done !== 1'b0) $display("FAIL sw_done_pulse: got %b want 0", o_done); else pass++;
  endtask

  task automatic test_load(input string nm, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rd, input logic [31:0] exp);
    issue(1'b1, 1'b0, f3, a, 32'hFFFF_FFFF);
    tick; i_valid = 1'b0; mem_if.ack = 1'b1; mem_if.rdata = rd; #1;
    total++; if ({mem_if.req, mem_if.we, mem_if.bmask} !== 6'b101111) $display("FAIL %s_req_we_bmask: got %b want 101111", nm, {mem_if.req, mem_if.we, mem_if.bmask}); else pass++;
    total++; if (mem_if.wdata !== 32'h0 || mem_if.addr !== {a[31:2], 2'b00}) $display("FAIL %s_wdata_addr: got %h/%h want 00000000/%h", nm, mem_if.wdata, mem_if.addr, {a[31:2], 2'b00}); else pass++;
    tick; mem_if.ack = 1'b0; mem_if.rdata = 32'h0; #1;
    total++; if (o_done !== 1'b1 || o_ld_data !== exp) $display("FAIL %s_ld_data: got done=%b %h want done=1 %h", nm, o_done, o_ld_data, exp); else pass++;
    tick;
  endtask

  task automatic test_store_lanes(input string nm, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [3:0] exp_bm,
                                  input logic [31:0] exp_wd, input logic [31:0] exp_a);
    issue(1'b0, 1'b1, f3, a, wd);
    tick; i_valid = 1'b0; mem_if.ack = 1'b1; #1;
    total++; if (mem_if.bmask !== exp_bm) $display("FAIL %s_bmask: got %b want %b", nm, mem_if.bmask, exp_bm); else pass++;
    total++; if (mem_if.wdata !== exp_wd) $display("FAIL %s_wdata: got %h want %h", nm, mem_if.wdata, exp_wd); else pass++;
    total++; if (mem_if.addr !== exp_a) $display("FAIL %s_addr: got %h want %h", nm, mem_if.addr, exp_a); else pass++;
    tick; mem_if.ack = 1'b0; tick;
  endtask

  task automatic test_misaligned(input string nm, input logic ld, input logic [2:0] f3, input logic [31:0] a);
    issue(ld, ~ld, f3, a, 32'h0); #1;
    total++; if (o_stall !== 1'b1) $display("FAIL %s_stall_accept: got %b want 1", nm, o_stall); else pass++;
    tick; i_valid = 1'b0; #1;
    total++; if ({mem_if.req, o_done, o_misaligned, o_bus_err, o_stall} !== 5'b01100) $display("FAIL %s_flags: got %b want 01100", nm, {mem_if.req, o_done, o_misaligned, o_bus_err, o_stall}); else pass++;
    tick;
    total++; if ({o_done, o_misaligned, mem_if.req} !== 3'b000) $display("FAIL %s_after: got %b want 000", nm, {o_done, o_misaligned, mem_if.req}); else pass++;
  endtask

  task automatic test_nonmem;
    issue(1'b0, 1'b0, 3'b000, 32'h100, 32'h0); mem_if.ack = 1'b1; #1;
    total++; if (o_stall !== 1'b0) $display("FAIL nonmem_stall: got %b want 0", o_stall); else pass++;
    tick; tick; i_valid = 1'b0; mem_if.ack = 1'b0; #1;
    total++; if ({o_done, mem_if.req} !== 2'b00) $display("FAIL idle_ack_ignored: got %b want 00", {o_done, mem_if.req}); else pass++;
  endtask

  task automatic test_back_to_back;
    int n;
    issue(1'b1, 1'b0, 3'b001, 32'h40, 32'h0);
    tick; i_valid = 1'b0;
    n = 0;
    while (mem_if.req === 1'b1 && n < 40) begin n++; tick; end
    total++; if (n !== 16) $display("FAIL timeout_req_cycles: got %0d want 16", n); else pass++;
    total++; if ({o_done, o_bus_err, o_misaligned, o_stall} !== 4'b1100 || o_ld_data !== 32'h0) $display("FAIL timeout_done: got %b %h want 1100 00000000", {o_done, o_bus_err, o_misaligned, o_stall}, o_ld_data); else pass++;
    issue(1'b1, 1'b0, 3'b010, 32'h44, 32'h0); #1;
    total++; if (o_stall !== 1'b0) $display("FAIL b2b_not_accepted_in_done: got %b want 0", o_stall); else pass++;
    tick;
    total++; if ({o_stall, o_done, o_bus_err} !== 3'b100) $display("FAIL b2b_accept_idle: got %b want 100", {o_stall, o_done, o_bus_err}); else pass++;
    tick; i_valid = 1'b0; mem_if.ack = 1'b1; mem_if.rdata = 32'h1234_5678; #1;
    total++; if (mem_if.req !== 1'b1 || mem_if.addr !== 32'h44) $display("FAIL b2b_req: got %b %h want 1 00000044", mem_if.req, mem_if.addr); else pass++;
    tick; mem_if.ack = 1'b0; #1;
    total++; if (o_done !== 1'b1 || o_ld_data !== 32'h1234_5678 || o_bus_err !== 1'b0) $display("FAIL b2b_ld_data: got %b %h %b want 1 12345678 0", o_done, o_ld_data, o_bus_err); else pass++;
    tick;
  endtask

  task automatic test_reset_mid;
    issue(1'b1, 1'b0, 3'b010, 32'h80, 32'h0);
    tick; tick; #1;
    total++; if ({mem_if.req, o_stall} !== 2'b11) $display("FAIL rst_mid_pre: got %b want 11", {mem_if.req, o_stall}); else pass++;
    i_rst_n = 1'b0; #1;
    total++; if ({mem_if.req, o_stall, o_done} !== 3'b000) $display("FAIL rst_mid_drop: got %b want 000", {mem_if.req, o_stall, o_done}); else pass++;
    i_valid = 1'b0;
    tick; i_rst_n = 1'b1;
    tick;
    total++; if ({mem_if.req, o_done} !== 2'b00) $display("FAIL rst_mid_idle: got %b want 00", {mem_if.req, o_done}); else pass++;
    test_load("rst_lw", 3'b010, 32'h84, 32'hCAFE_F00D, 32'hCAFE_F00D);
  endtask

  initial begin
    pass = 0; total = 0;
    i_rst_n = 1'b0; i_valid = 1'b0; i_is_load = 1'b0; i_is_store = 1'b0;
    i_funct3 = 3'b0; i_addr = 32'h0; i_wdata = 32'h0;
    mem_if.ack = 1'b0; mem_if.rdata = 32'h0;
    test_reset;
    test_sw;
    test_load("lb", 3'b000, 32'h203, 32'h80FF_1234, 32'hFFFF_FF80);
    test_load("lbu", 3'b100, 32'h203, 32'h80FF_1234, 32'h0000_0080);
    test_load("lh", 3'b001, 32'h202, 32'h80FF_1234, 32'hFFFF_80FF);
    test_load("lhu", 3'b101, 32'h202, 32'h80FF_1234, 32'h0000_80FF);
    test_load("lw", 3'b010, 32'h200, 32'h80FF_1234, 32'h80FF_1234);
    test_load("lb0", 3'b000, 32'h200, 32'h80FF_1274, 32'h0000_0074);
    test_store_lanes("sh", 3'b001, 32'h12, 32'h0000_ABCD, 4'b1100, 32'hABCD_ABCD, 32'h10);
    test_store_lanes("sb", 3'b000, 32'h11, 32'h1234_565A, 4'b0010, 32'h5A5A_5A5A, 32'h10);
    test_misaligned("lw_mis", 1'b1, 3'b010, 32'h6);
    test_misaligned("lh_mis", 1'b1, 3'b001, 32'h41);
    test_misaligned("st_f3_ill", 1'b0, 3'b100, 32'h0);
    test_misaligned("ld_f3_ill", 1'b1, 3'b110, 32'h0);
    test_nonmem;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
